// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// default widths and the depth/full rule of the downstream 8-entry FIFO.
package fifo_pkg;

    localparam int DW_DEFAULT   = 8;
    localparam int LENW_DEFAULT = 2;
    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_CAP     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_e;

    // One slot is sacrificed so that full and empty stay distinguishable.
    function automatic logic fifo_is_full(input logic [2:0] wptr, input logic [2:0] rptr);
        return (wptr + 3'd1) == rptr;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle seen by the write arbiter.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int LENW = LENW_DEFAULT
);
    logic            req0;
    logic            req1;
    logic [LENW-1:0] len0;
    logic [LENW-1:0] len1;
    logic [DW-1:0]   data0;
    logic [DW-1:0]   data1;
    logic            flush;
    logic            fifo_full;
    logic            grant0;
    logic            grant1;
    logic            ack0;
    logic            ack1;
    logic            fifo_wren;
    logic [DW-1:0]   fifo_din;
    logic            fifo_sclr;
    logic            busy;

    modport master (
        output req0, req1, len0, len1, data0, data1, flush, fifo_full,
        input  grant0, grant1, ack0, ack1, fifo_wren, fifo_din, fifo_sclr, busy
    );

    modport slave (
        input  req0, req1, len0, len1, data0, data1, flush, fifo_full,
        output grant0, grant1, ack0, ack1, fifo_wren, fifo_din, fifo_sclr, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// Two-input round-robin picker; prio names the producer favoured on a tie.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic winner,
    output logic valid
);

    // Tie goes to prio, otherwise the sole requester wins.
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = prio;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single FIFO write port between two burst producers: round-robin
// grants held for a whole burst, stalls on full, flush aborts and clears.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int LENW = LENW_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    fifo_wr_arbiter_if.slave bus
);

    arb_state_e      state_r, state_s;
    logic            prio_r, prio_s;
    logic            owner_r, owner_s;
    logic [LENW-1:0] beat_cnt_r, beat_cnt_s;
    logic [LENW-1:0] len_q_r, len_q_s;
    logic            grant0_r, grant1_r, sclr_r, busy_r;
    logic            win_s, win_valid_s;
    logic            wren_s, last_s;
    logic [DW-1:0]   din_s;

    rr_arb2 u_rr_arb2 (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .prio   (prio_r),
        .winner (win_s),
        .valid  (win_valid_s)
    );

    // Write strobe and data mux for the beat currently on the owner's bus.
    always_comb begin
        wren_s = (state_r == ST_BURST) && !bus.fifo_full && !bus.flush;
        last_s = wren_s && (beat_cnt_r == len_q_r);
        if (state_r == ST_BURST) begin
            din_s = owner_r ? bus.data1 : bus.data0;
        end else begin
            din_s = '0;
        end
    end

    // Next-state logic; flush overrides everything except reset.
    always_comb begin
        state_s    = state_r;
        prio_s     = prio_r;
        owner_s    = owner_r;
        beat_cnt_s = beat_cnt_r;
        len_q_s    = len_q_r;
        if (bus.flush) begin
            state_s    = ST_FLUSH;
            beat_cnt_s = '0;
            if (state_r == ST_BURST) begin
                prio_s = ~owner_r;
            end else begin
                prio_s = prio_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        state_s    = ST_BURST;
                        owner_s    = win_s;
                        len_q_s    = win_s ? bus.len1 : bus.len0;
                        beat_cnt_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (last_s) begin
                        state_s    = ST_IDLE;
                        prio_s     = ~owner_r;
                        beat_cnt_s = '0;
                    end else if (wren_s) begin
                        beat_cnt_s = beat_cnt_r + LENW'(1);
                    end else begin
                        beat_cnt_s = beat_cnt_r;
                    end
                end
                ST_FLUSH: state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State, counters and the registered grant/busy/sclr outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            prio_r     <= 1'b0;
            owner_r    <= 1'b0;
            beat_cnt_r <= '0;
            len_q_r    <= '0;
            grant0_r   <= 1'b0;
            grant1_r   <= 1'b0;
            sclr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            prio_r     <= prio_s;
            owner_r    <= owner_s;
            beat_cnt_r <= beat_cnt_s;
            len_q_r    <= len_q_s;
            grant0_r   <= (state_s == ST_BURST) && !owner_s;
            grant1_r   <= (state_s == ST_BURST) && owner_s;
            sclr_r     <= (state_s == ST_FLUSH);
            busy_r     <= (state_s == ST_BURST);
        end
    end

    assign bus.grant0    = grant0_r;
    assign bus.grant1    = grant1_r;
    assign bus.busy      = busy_r;
    assign bus.fifo_sclr = sclr_r;
    assign bus.fifo_wren = wren_s;
    assign bus.fifo_din  = din_s;
    assign bus.ack0      = wren_s && !owner_r;
    assign bus.ack1      = wren_s && owner_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected beats are queued at stimulus
// time and a negedge monitor pops and compares every FIFO write.
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    fifo_wr_arbiter_if #(.DW(8), .LENW(2)) bus ();

    fifo_wr_arbiter #(.DW(8), .LENW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         wr_count = 0;
    int         wc0;
    exp_t       exp_q[$];
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] idx0 = 8'd0;
    logic [7:0] idx1 = 8'd0;
    logic       ack0_q = 1'b0;
    logic       ack1_q = 1'b0;
    logic       full_force, model_en, rd;
    logic [2:0] wp = 3'd0;
    logic [2:0] rp = 3'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Producers present mem[idx] and step to the next beat after each ack.
    assign bus.data0 = mem0[idx0];
    assign bus.data1 = mem1[idx1];
    always @(posedge clk) begin
        if (ack0_q) idx0 <= idx0 + 8'd1;
        if (ack1_q) idx1 <= idx1 + 8'd1;
    end

    // Downstream FIFO occupancy model (pointer pair, 7 usable slots).
    always @(posedge clk) begin
        if (reset || bus.fifo_sclr) begin
            wp <= 3'd0;
            rp <= 3'd0;
        end else begin
            if (bus.fifo_wren) wp <= wp + 3'd1;
            if (rd) rp <= rp + 3'd1;
        end
    end
    assign bus.fifo_full = full_force | (model_en & fifo_is_full(wp, rp));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        ack0_q <= bus.ack0;
        ack1_q <= bus.ack1;
        chk("ack_vs_wren", {31'd0, bus.ack0 | bus.ack1}, {31'd0, bus.fifo_wren});
        if (bus.fifo_wren) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {24'd0, bus.fifo_din}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", {24'd0, bus.fifo_din}, {24'd0, e.data});
                chk("beat_port", {31'd0, bus.ack1}, {31'd0, e.port});
            end
        end
    end

    // Advance to just after the next rising edge; producers drop req once granted.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.grant0) bus.req0 = 1'b0;
        if (bus.grant1) bus.req1 = 1'b0;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Load four beats for producer p and queue the first n as expected writes.
    task automatic ld(input logic p, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3, input int n);
        logic [7:0] d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            if (p) mem1[8'(idx1 + 8'(i))] = d[i];
            else   mem0[8'(idx0 + 8'(i))] = d[i];
            if (i < n) exp_q.push_back('{p, d[i]});
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.req0 || bus.req1) && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, n, (n < 40) ? n : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.len0 = 2'd0; bus.len1 = 2'd0;
        bus.flush = 1'b0; full_force = 1'b0; model_en = 1'b0; rd = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'd0;
            mem1[i] = 8'd0;
        end
        do_reset();

        // Single 4-beat burst from producer 0, then prio must favour producer 1
        ld(1'b0, 8'h11, 8'h12, 8'h13, 8'h14, 4);
        bus.req0 = 1'b1; bus.len0 = 2'd3;
        neg();
        chk("rst_grant0", {31'd0, bus.grant0}, 32'd0);
        chk("rst_grant1", {31'd0, bus.grant1}, 32'd0);
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_sclr",   {31'd0, bus.fifo_sclr}, 32'd0);
        chk("rst_wren",   {31'd0, bus.fifo_wren}, 32'd0);
        chk("rst_din",    {24'd0, bus.fifo_din},  32'd0);
        tick(); neg();
        chk("t1_grant0", {31'd0, bus.grant0}, 32'd1);
        chk("t1_busy",   {31'd0, bus.busy},   32'd1);
        chk("t1_wren",   {31'd0, bus.fifo_wren}, 32'd1);
        repeat (3) begin
            tick(); neg();
            chk("t1_wren_run", {31'd0, bus.fifo_wren}, 32'd1);
        end
        tick(); neg();
        chk("t1_busy_drop",  {31'd0, bus.busy},   32'd0);
        chk("t1_grant_drop", {31'd0, bus.grant0}, 32'd0);
        tick();
        ld(1'b1, 8'h15, 8'h00, 8'h00, 8'h00, 1);
        ld(1'b0, 8'h16, 8'h00, 8'h00, 8'h00, 1);
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 2'd0; bus.len1 = 2'd0;
        tick(); neg();
        chk("t1_prio_grant1", {31'd0, bus.grant1}, 32'd1);
        chk("t1_prio_grant0", {31'd0, bus.grant0}, 32'd0);
        drain("t1");

        // Contention from reset: 0 then 1, one idle cycle between
        do_reset();
        ld(1'b0, 8'h21, 8'h22, 8'h00, 8'h00, 2);
        ld(1'b1, 8'h31, 8'h32, 8'h00, 8'h00, 2);
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 2'd1; bus.len1 = 2'd1;
        neg();
        chk("t2_arb_wren", {31'd0, bus.fifo_wren}, 32'd0);
        tick(); neg();
        chk("t2_grant0", {31'd0, bus.grant0}, 32'd1);
        chk("t2_grant1_low", {31'd0, bus.grant1}, 32'd0);
        tick(); neg();
        tick(); neg();
        chk("t2_gap_grant0", {31'd0, bus.grant0}, 32'd0);
        chk("t2_gap_wren",   {31'd0, bus.fifo_wren}, 32'd0);
        tick(); neg();
        chk("t2_grant1", {31'd0, bus.grant1}, 32'd1);
        tick(); neg();
        tick();
        ld(1'b0, 8'h23, 8'h00, 8'h00, 8'h00, 1);
        ld(1'b1, 8'h33, 8'h00, 8'h00, 8'h00, 1);
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 2'd0; bus.len1 = 2'd0;
        tick(); neg();
        chk("t2_next_grant0", {31'd0, bus.grant0}, 32'd1);
        drain("t2");

        // Full stall for 3 cycles after beat 2 of 4
        do_reset();
        wc0 = wr_count;
        ld(1'b0, 8'h41, 8'h42, 8'h43, 8'h44, 4);
        bus.req0 = 1'b1; bus.len0 = 2'd3;
        tick(); neg();
        tick(); neg();
        tick();
        full_force = 1'b1;
        repeat (3) begin
            neg();
            chk("t3_stall_wren",  {31'd0, bus.fifo_wren}, 32'd0);
            chk("t3_stall_grant", {31'd0, bus.grant0},    32'd1);
            tick();
        end
        full_force = 1'b0;
        neg();
        chk("t3_resume_wren", {31'd0, bus.fifo_wren}, 32'd1);
        tick(); neg();
        chk("t3_last_wren", {31'd0, bus.fifo_wren}, 32'd1);
        tick(); neg();
        chk("t3_busy_drop", {31'd0, bus.busy}, 32'd0);
        chk("t3_writes", 32'(wr_count - wc0), 32'd4);

        // Flush during producer 1's second beat; pending req0 wins afterwards
        do_reset();
        ld(1'b1, 8'h51, 8'h52, 8'h53, 8'h54, 1);
        bus.req1 = 1'b1; bus.len1 = 2'd3;
        tick();
        ld(1'b0, 8'h61, 8'h00, 8'h00, 8'h00, 1);
        bus.req0 = 1'b1; bus.len0 = 2'd0;
        neg();
        chk("t4_grant1", {31'd0, bus.grant1}, 32'd1);
        tick();
        bus.flush = 1'b1;
        neg();
        chk("t4_flush_wren", {31'd0, bus.fifo_wren}, 32'd0);
        tick();
        bus.flush = 1'b0;
        neg();
        chk("t4_sclr",        {31'd0, bus.fifo_sclr}, 32'd1);
        chk("t4_grant1_drop", {31'd0, bus.grant1},    32'd0);
        chk("t4_busy_drop",   {31'd0, bus.busy},      32'd0);
        chk("t4_sclr_wren",   {31'd0, bus.fifo_wren}, 32'd0);
        tick(); neg();
        chk("t4_sclr_once",   {31'd0, bus.fifo_sclr}, 32'd0);
        chk("t4_idle_grant0", {31'd0, bus.grant0},    32'd0);
        tick(); neg();
        chk("t4_req0_wins", {31'd0, bus.grant0}, 32'd1);
        drain("t4");
        bus.flush = 1'b1;
        tick(); neg();
        chk("t4_hold_sclr1", {31'd0, bus.fifo_sclr}, 32'd1);
        tick();
        bus.flush = 1'b0;
        neg();
        chk("t4_hold_sclr2", {31'd0, bus.fifo_sclr}, 32'd1);
        tick(); neg();
        chk("t4_hold_release", {31'd0, bus.fifo_sclr}, 32'd0);

        // Reset mid-burst clears prio back to producer 0
        do_reset();
        ld(1'b0, 8'h70, 8'h00, 8'h00, 8'h00, 1);
        bus.req0 = 1'b1; bus.len0 = 2'd0;
        tick(); neg();
        tick();
        ld(1'b1, 8'h71, 8'h72, 8'h73, 8'h74, 2);
        bus.req1 = 1'b1; bus.len1 = 2'd3;
        tick(); neg();
        chk("t5_grant1", {31'd0, bus.grant1}, 32'd1);
        tick();
        reset = 1'b1;
        neg();
        tick();
        reset = 1'b0;
        ld(1'b0, 8'h75, 8'h00, 8'h00, 8'h00, 1);
        ld(1'b1, 8'h76, 8'h00, 8'h00, 8'h00, 1);
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.len0 = 2'd0; bus.len1 = 2'd0;
        neg();
        chk("t5_grant0_zero", {31'd0, bus.grant0},    32'd0);
        chk("t5_grant1_zero", {31'd0, bus.grant1},    32'd0);
        chk("t5_busy_zero",   {31'd0, bus.busy},      32'd0);
        chk("t5_sclr_zero",   {31'd0, bus.fifo_sclr}, 32'd0);
        chk("t5_wren_zero",   {31'd0, bus.fifo_wren}, 32'd0);
        tick(); neg();
        chk("t5_prio_grant0", {31'd0, bus.grant0}, 32'd1);
        drain("t5");

        // Fill to capacity: 7 writes accepted, 8th waits for a read
        do_reset();
        model_en = 1'b1;
        wc0 = wr_count;
        ld(1'b0, 8'h81, 8'h82, 8'h83, 8'h84, 4);
        bus.req0 = 1'b1; bus.len0 = 2'd3;
        drain("t6a");
        ld(1'b0, 8'h85, 8'h86, 8'h87, 8'h88, 4);
        bus.req0 = 1'b1; bus.len0 = 2'd3;
        tick(); neg();
        tick(); neg();
        tick(); neg();
        tick(); neg();
        chk("t6_full_wren",  {31'd0, bus.fifo_wren}, 32'd0);
        chk("t6_accepted",   32'(wr_count - wc0), 32'd7);
        chk("t6_full_grant", {31'd0, bus.grant0}, 32'd1);
        tick(); neg();
        chk("t6_still_full", {31'd0, bus.fifo_wren}, 32'd0);
        tick();
        rd = 1'b1;
        neg();
        chk("t6_read_cycle", {31'd0, bus.fifo_wren}, 32'd0);
        tick();
        rd = 1'b0;
        neg();
        chk("t6_eighth_wren", {31'd0, bus.fifo_wren}, 32'd1);
        drain("t6b");
        chk("t6_total", 32'(wr_count - wc0), 32'd8);
        model_en = 1'b0;

        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 8-bit FIFO between two producers.
- Grants are round-robin. Each grant holds for a fixed-length burst of up to 4 beats, so one producer's beats stay contiguous in the FIFO.
- The block drives the FIFO's wren, din and sclr.
- Beats stall while the FIFO is full. A flush request aborts the current burst and clears the FIFO.

Parameters:
- DW, 8, data width; must match the FIFO din width.
- LENW, 2, burst length field width; length encoded as beats-1, so 1..4 beats.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; clears all state.
- req0  in  1  producer 0 requests a burst; hold until its grant0 rises.
- len0  in  LENW  producer 0 burst length minus 1; sampled on the grant cycle.
- data0  in  DW  producer 0 beat data; must be valid every cycle grant0=1.
- req1, len1, data1  in  1/LENW/DW  same for producer 1.
- flush  in  1  abort the current burst and clear the FIFO.
- fifo_full  in  1  FIFO full flag.
- grant0, grant1  out  1  registered; high for the whole burst of the owner.
- ack0, ack1  out  1  combinational; the beat on dataN is written this cycle.
- fifo_wren  out  1  combinational FIFO write enable.
- fifo_din  out  DW  combinational mux of data0/data1 by owner; 0 when idle.
- fifo_sclr  out  1  registered FIFO synchronous clear.
- busy  out  1  registered; high in BURST state.

Behaviour:
- Reset: state=IDLE, prio=0 (producer 0 favoured), owner=0, beat_cnt=0, len_q=0.
  - All outputs 0 the cycle after reset is sampled high.
  - Reset has priority over flush and every other input.
- States: IDLE, BURST, FLUSH.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one reqN: owner<=N, len_q<=lenN, beat_cnt<=0, go to BURST.
  - Both requests: owner<=prio, then as above.
  - grantN rises the cycle after the IDLE decision.
- BURST:
  - grantN = (owner==N).
  - fifo_wren = ~fifo_full & ~flush.
  - ackN = fifo_wren & (owner==N).
  - fifo_din = owner's data.
  - On each fifo_wren: beat_cnt<=beat_cnt+1.
  - When fifo_wren is high and beat_cnt==len_q: go to IDLE, prio<=~owner, grants drop next cycle.
  - No idle gap between back-to-back bursts beyond the single IDLE arbitration cycle.
- Full stall: while fifo_full=1 in BURST, no wren, no ack; beat_cnt, owner and grant are held; the producer holds its data.
- Flush (sampled in any state other than reset):
  - Go to FLUSH; fifo_sclr=1 for exactly one cycle (the FLUSH state); grants drop.
  - No wren in the flush cycle.
  - Mid-burst abort: beat_cnt is discarded and prio<=~owner.
  - FLUSH returns to IDLE the next cycle.
  - flush held high re-enters FLUSH every cycle; fifo_sclr stays high.
- Request withdrawal: a producer that drops reqN before its grant simply loses arbitration; dropping req mid-burst is ignored (the burst completes).
- Counter width: beat_cnt is LENW bits; compared to len_q, never wraps within a burst.
- Single-beat burst (len=0): one ack, then IDLE.

Decomposition:
- Shared package fifo_pkg:
  - state encoding constants ST_IDLE, ST_BURST, ST_FLUSH;
  - DW and LENW defaults;
  - FIFO depth constant 8, with usable capacity 7 (full when w+1==r).
- Sub-module rr_arb2: 2-input round-robin picker (req0, req1, prio -> winner, valid), purely combinational.
- The FSM, counters and output mux live in fifo_wr_arbiter.

Test Plan:
- Single request: req0=1, len0=3, data0=0x11..0x14, fifo_full=0.
  - grant0 rises 1 cycle later.
  - ack0/fifo_wren high 4 consecutive cycles with din 0x11,0x12,0x13,0x14.
  - busy drops, prio=1.
- Contention: req0=req1=1 from reset, len=1 each.
  - Producer 0 bursts 2 beats, one IDLE cycle, then producer 1 bursts 2 beats.
  - Next contention goes to producer 0 again.
- Full stall: mid-burst at beat 2 of 4, fifo_full=1 for 3 cycles.
  - No wren or ack for 3 cycles; grant is held.
  - Beats 3 and 4 follow immediately after full drops; exactly 4 writes total.
- Flush mid-burst: producer 1 bursting, flush pulsed at beat 1.
  - fifo_sclr=1 for one cycle, no wren that cycle, grant1 drops.
  - IDLE follows, then a pending req0 wins.
- Reset mid-burst: reset=1 one cycle during a burst.
  - All outputs 0 the next cycle, prio=0; a subsequent contention grants producer 0.
- Fill to capacity: producer 0 issues two len=3 bursts with the FIFO model honouring full at 7 entries.
  - Exactly 7 writes are accepted, the 8th beat stalls until a read frees an entry.
